dcache_wt: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the pipeline memory stage and the backing data memory.
- Filters load traffic to the backing memory and stalls the pipeline on misses and stores.
- Backing side drives the data memory's word/byte (LBU/SB) access semantics through a req/ready handshake.
- Loads hit in zero added cycles.

---
 rtl/dcache_wt.sv | 184 ++++++++++++++++++
 tb/tb_dcache_wt.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache between the memory stage and data memory.
// Latency: load hit 0 cycles; load miss WORDS_PER_LINE+1 stall cycles; store 1 stall cycle (ready high).
// Backpressure: stall_o holds the pipeline; mem_ready_i low holds the backing request and extends the stall.
module dcache_wt #(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_re_i,
  input  logic                  cpu_we_i,
  input  logic                  cpu_byte_op_i,
  input  logic [DATA_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wd_i,
  output logic [DATA_WIDTH-1:0] cpu_rd_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic                  mem_byte_op_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i,
  input  logic                  mem_ready_i
);

  localparam int LANES  = DATA_WIDTH / BYTE_WIDTH;
  localparam int OFF_W  = $clog2(LANES);
  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(SETS);
  localparam int LINE_W = DATA_WIDTH - WORD_W - OFF_W;
  localparam int TAG_W  = LINE_W - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_WRITE
  } state_t;

  state_t state_q, state_d;

  // Line address of the refill in flight; its low bits are the set, the rest the tag.
  logic [LINE_W-1:0] line_q;
  logic [WORD_W-1:0] k_q;

  logic                  valid_q  [SETS];
  logic [TAG_W-1:0]      tag_mem  [SETS];
  logic [DATA_WIDTH-1:0] data_mem [SETS][WORDS_PER_LINE];

  logic [OFF_W-1:0]      cpu_off;
  logic [WORD_W-1:0]     cpu_word;
  logic [LINE_W-1:0]     cpu_line;
  logic [IDX_W-1:0]      cpu_idx;
  logic [TAG_W-1:0]      cpu_tag;
  logic [IDX_W-1:0]      ref_idx;
  logic [TAG_W-1:0]      ref_tag;
  logic                  hit;
  logic                  refill_last;
  logic [DATA_WIDTH-1:0] sel_word;
  logic [BYTE_WIDTH-1:0] sel_byte;
  logic [DATA_WIDTH-1:0] store_word;
  logic [DATA_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] refill_addr;

  assign cpu_off     = cpu_addr_i[OFF_W-1:0];
  assign cpu_word    = cpu_addr_i[OFF_W +: WORD_W];
  assign cpu_line    = cpu_addr_i[DATA_WIDTH-1:OFF_W+WORD_W];
  assign cpu_idx     = cpu_line[IDX_W-1:0];
  assign cpu_tag     = cpu_line[LINE_W-1:IDX_W];
  assign ref_idx     = line_q[IDX_W-1:0];
  assign ref_tag     = line_q[LINE_W-1:IDX_W];

  assign hit         = (cpu_re_i | cpu_we_i) & valid_q[cpu_idx] & (tag_mem[cpu_idx] == cpu_tag);
  assign refill_last = (k_q == WORD_W'(WORDS_PER_LINE - 1));
  assign sel_word    = data_mem[cpu_idx][cpu_word];
  assign sel_byte    = sel_word[cpu_off*BYTE_WIDTH +: BYTE_WIDTH];
  assign word_addr   = {cpu_addr_i[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign refill_addr = {line_q, k_q, {OFF_W{1'b0}}};

  // Merge a store into the cached word: one lane for byte stores, whole word otherwise.
  always_comb begin
    store_word = cpu_wd_i;
    if (cpu_byte_op_i) begin
      store_word = sel_word;
      store_word[cpu_off*BYTE_WIDTH +: BYTE_WIDTH] = cpu_wd_i[BYTE_WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: stores always go through WRITE (stores win over simultaneous loads); load misses refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_we_i)                state_d = S_WRITE;
        else if (cpu_re_i && !hit)   state_d = S_REFILL;
      end
      S_REFILL: begin
        if (mem_ready_i && refill_last) state_d = S_IDLE;
      end
      S_WRITE: begin
        if (mem_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: pipeline stall, backing request and load data; unused values are driven to 0.
  always_comb begin
    stall_o       = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_byte_op_o = 1'b0;
    mem_addr_o    = '0;
    mem_wd_o      = '0;
    cpu_rd_o      = '0;
    case (state_q)
      S_IDLE: begin
        if (cpu_we_i) begin
          stall_o = 1'b1;
        end else if (cpu_re_i) begin
          if (hit) cpu_rd_o = cpu_byte_op_i ? {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, sel_byte} : sel_word;
          else     stall_o  = 1'b1;
        end
      end
      S_REFILL: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = refill_addr;
      end
      S_WRITE: begin
        stall_o       = ~mem_ready_i;
        mem_req_o     = 1'b1;
        mem_we_o      = 1'b1;
        mem_byte_op_o = cpu_byte_op_i;
        mem_addr_o    = cpu_byte_op_i ? cpu_addr_i : word_addr;
        mem_wd_o      = cpu_wd_i;
      end
      default: ;
    endcase
  end

  // Capture the missing line and step the beat counter as refill words arrive.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      k_q    <= '0;
    end else if (state_q == S_IDLE && cpu_re_i && !cpu_we_i && !hit) begin
      line_q <= cpu_line;
      k_q    <= '0;
    end else if (state_q == S_REFILL && mem_ready_i) begin
      k_q    <= k_q + WORD_W'(1);
    end
  end

  // Valid bits: cleared by reset, set only once the final refill beat lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) valid_q[i] <= 1'b0;
    end else if (state_q == S_REFILL && mem_ready_i && refill_last) begin
      valid_q[ref_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: refill beats, and store hits kept coherent with memory.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_REFILL && mem_ready_i) begin
        data_mem[ref_idx][k_q] <= mem_rd_i;
        if (refill_last) tag_mem[ref_idx] <= ref_tag;
      end
      if (state_q == S_WRITE && mem_ready_i && hit) begin
        data_mem[cpu_idx][cpu_word] <= store_word;
      end
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: directed scenarios plus randomized loads/stores.
// Expected data comes from a backing-memory array; hit/miss from a per-set resident-line table.
// Backing memory is modelled here and answers with bench-chosen ready patterns.
module tb_dcache_wt;

  localparam int          WPL    = 4;
  localparam int          MWORDS = 4096;
  localparam logic [31:0] BASE   = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we, cpu_bop;
  logic [31:0] cpu_addr, cpu_wd, cpu_rd;
  logic        stall_o, mem_req_o, mem_we_o, mem_byte_op_o;
  logic [31:0] mem_addr_o, mem_wd_o, mem_rd;
  logic        mem_ready;

  always #5 clk = ~clk;

  dcache_wt dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_re_i     (cpu_re),
    .cpu_we_i     (cpu_we),
    .cpu_byte_op_i(cpu_bop),
    .cpu_addr_i   (cpu_addr),
    .cpu_wd_i     (cpu_wd),
    .cpu_rd_o     (cpu_rd),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_byte_op_o(mem_byte_op_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd),
    .mem_ready_i  (mem_ready)
  );

  logic [31:0] bmem [MWORDS];
  int          model_line [64];
  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] addr_log [$];
  int          wr_cnt, waits_g, stalls_g;
  logic [31:0] wr_addr, wr_dat, rd_g;
  logic        wr_bop;
  bit          rnd_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    if (a >= BASE && a < BASE + 32'(4 * MWORDS)) return int'((a - BASE) >> 2);
    return 0;
  endfunction

  // Run one access to completion; acts as backing memory and records what it saw.
  task automatic access(input logic re, input logic we, input logic bop, input logic [31:0] addr,
                        input logic [31:0] wd, input int hb, input int hl, input int abort_cyc);
    int          beats, held, lane, i;
    bit          done;
    logic [31:0] w;
    beats = 0; held = 0; done = 0;
    waits_g = 0; stalls_g = 0; wr_cnt = 0; rd_g = '0;
    addr_log.delete();
    @(negedge clk);
    cpu_re = re; cpu_we = we; cpu_bop = bop; cpu_addr = addr; cpu_wd = wd;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (cyc == abort_cyc) begin
        rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (beats == hb && held < hl) begin
        mem_ready = 1'b0;
        held++;
      end else begin
        mem_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      #1;
      mem_rd = bmem[widx(mem_addr_o)];
      #1;
      if (mem_req_o) begin
        addr_log.push_back(mem_addr_o);
        if (!mem_ready) begin
          waits_g++;
        end else if (mem_we_o) begin
          wr_cnt++; wr_addr = mem_addr_o; wr_dat = mem_wd_o; wr_bop = mem_byte_op_o;
          i = widx(mem_addr_o);
          if (mem_byte_op_o) begin
            w = bmem[i];
            lane = int'(mem_addr_o[1:0]);
            w[lane*8 +: 8] = mem_wd_o[7:0];
            bmem[i] = w;
          end else begin
            bmem[i] = mem_wd_o;
          end
        end else begin
          beats++;
        end
      end
      if (!stall_o) begin
        rd_g = cpu_rd;
        done = 1;
      end else begin
        stalls_g++;
        @(negedge clk);
      end
    end
    check("done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  // One access checked against the reference: memory contents plus resident-line table.
  task automatic do_op(input logic re, input logic we, input logic bop, input logic [31:0] addr,
                       input logic [31:0] wd, input int hb, input int hl);
    logic [31:0] line, wv, exp_rd, exp_addr;
    int          set, sh;
    bit          res;
    line   = addr >> 4;
    set    = int'(line & 32'd63);
    res    = (model_line[set] == int'(line));
    wv     = bmem[widx(addr)];
    sh     = 8 * int'(addr[1:0]);
    exp_rd = bop ? ((wv >> sh) & 32'hFF) : wv;
    access(re, we, bop, addr, wd, hb, hl, -1);
    if (we) begin
      exp_addr = bop ? addr : (addr & ~32'h3);
      check("st_stall", 32'(stalls_g), 32'(1 + waits_g));
      check("st_wrcnt", 32'(wr_cnt), 32'd1);
      check("st_addr", wr_addr, exp_addr);
      check("st_data", wr_dat, wd);
      check("st_bop", 32'(wr_bop), 32'(bop));
    end else begin
      check("ld_data", rd_g, exp_rd);
      check("ld_wrcnt", 32'(wr_cnt), 32'd0);
      if (res) begin
        check("ld_hit_stall", 32'(stalls_g), 32'd0);
        check("ld_hit_req", 32'(addr_log.size()), 32'd0);
      end else begin
        check("ld_miss_stall", 32'(stalls_g), 32'(WPL + 1 + waits_g));
        check("ld_miss_reqs", 32'(addr_log.size()), 32'(WPL + waits_g));
        check("ld_miss_first", addr_log[0], line << 4);
        check("ld_miss_last", addr_log[addr_log.size()-1], (line << 4) + 32'd12);
        model_line[set] = int'(line);
      end
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_stall"}, 32'(stall_o), 32'd0);
    check({tag, "_req"}, 32'(mem_req_o), 32'd0);
    check({tag, "_we"}, 32'(mem_we_o), 32'd0);
    check({tag, "_rd"}, cpu_rd, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    logic        bop;
    rst = 1'b1; cpu_re = 0; cpu_we = 0; cpu_bop = 0; cpu_addr = '0; cpu_wd = '0;
    mem_rd = '0; mem_ready = 1'b1; rnd_ready = 0;
    for (int i = 0; i < MWORDS; i++) bmem[i] = $urandom;
    for (int i = 0; i < 64; i++) model_line[i] = -1;
    bmem[0] = 32'hDEADBEEF; bmem[1] = 32'h11111111; bmem[2] = 32'h22222222; bmem[3] = 32'h33333333;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_check("reset");

    // Cold miss fill, then hits in the same line.
    do_op(1, 0, 0, 32'h10000, 0, -1, 0);
    check("fill_rd", rd_g, 32'hDEADBEEF);
    check("fill_stall", 32'(stalls_g), 32'd5);
    check("fill_a1", addr_log[1], 32'h10004);
    check("fill_a2", addr_log[2], 32'h10008);
    check("fill_a3", addr_log[3], 32'h1000C);
    do_op(1, 0, 0, 32'h10008, 0, -1, 0);
    check("hit8_rd", rd_g, 32'h22222222);
    do_op(1, 0, 1, 32'h10002, 0, -1, 0);
    check("lbu_rd", rd_g, 32'h000000AD);

    // Store hits keep the line coherent.
    do_op(0, 1, 0, 32'h10004, 32'hCAFEF00D, -1, 0);
    do_op(1, 0, 0, 32'h10004, 0, -1, 0);
    check("sw_rd", rd_g, 32'hCAFEF00D);
    do_op(0, 1, 1, 32'h10005, 32'hAAAAAA7F, -1, 0);
    do_op(1, 0, 0, 32'h10004, 0, -1, 0);
    check("sb_rd", rd_g, 32'hCAFE7F0D);

    // Store miss to a line aliasing set 0 allocates nothing.
    do_op(0, 1, 0, 32'h12000, 32'h5A5A1234, -1, 0);
    do_op(1, 0, 0, 32'h10000, 0, -1, 0);
    check("stmiss_keep", 32'(stalls_g), 32'd0);
    do_op(1, 0, 0, 32'h12000, 0, -1, 0);
    check("stmiss_refill", 32'(stalls_g), 32'd5);
    check("stmiss_rd", rd_g, 32'h5A5A1234);

    // Conflict replacement in set 0.
    do_op(1, 0, 0, 32'h10000, 0, -1, 0);
    do_op(1, 0, 0, 32'h10400, 0, -1, 0);
    do_op(1, 0, 0, 32'h10000, 0, -1, 0);
    check("conflict_miss", 32'(stalls_g), 32'd5);

    // Backing memory not ready for 3 cycles on beat 1.
    do_op(1, 0, 0, 32'h10800, 0, 1, 3);
    check("hold_stall", 32'(stalls_g), 32'd8);
    for (int i = 1; i <= 4; i++) check("hold_addr", addr_log[i], 32'h10804);
    check("hold_after", addr_log[5], 32'h10808);

    // Reset in the middle of a refill leaves nothing valid.
    access(1, 0, 0, 32'h10C00, 0, -1, 0, 3);
    for (int i = 0; i < 64; i++) model_line[i] = -1;
    idle_check("midrst");
    do_op(1, 0, 0, 32'h10C00, 0, -1, 0);
    check("midrst_miss", 32'(stalls_g), 32'd5);
    do_op(1, 0, 0, 32'h10800, 0, -1, 0);
    check("midrst_old", 32'(stalls_g), 32'd5);

    // Random mix with random backing-memory ready.
    rnd_ready = 1;
    repeat (250) begin
      r   = $urandom_range(0, 9);
      a   = BASE + ($urandom_range(0, 15) << 10) + ($urandom_range(0, 3) << 4) + $urandom_range(0, 15);
      bop = 1'($urandom_range(0, 1));
      do_op((r >= 4) || (r == 0), r < 4, bop, a, $urandom, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
